// File: rtl/sc_lane_shift_scheduler_if.sv
// sc_lane_shift_scheduler_if
// Bundles the control inputs and shift/round outputs of the lane shift
// scheduler so the level state machine side and the scheduler share one port.
//   SC_LANESCHED_LOAD_SHIFT_IN  : 1 = lanes being loaded, scheduler held idle
//   SC_LANESCHED_VEL_SELECT_IN  : 00 stopped, 01/10/11 pick a round period
//   SC_LANESCHED_PAUSE_IN       : freeze counting and issuing
//   SC_LANESCHED_LANE_EN_IN     : per-lane enable mask
//   SC_LANESCHED_SHIFT_OUT      : one-hot-or-zero shift-enable pulses
//   SC_LANESCHED_ROUND_DONE_OUT : pulse on the last lane slot of a round
//   SC_LANESCHED_ROUNDS_OUT     : completed-round counter
//   SC_LANESCHED_STATE_OUT      : debug state code
interface sc_lane_shift_scheduler_if #(
  parameter int NUM_LANES = 4
);
  logic                 SC_LANESCHED_LOAD_SHIFT_IN;
  logic [1:0]           SC_LANESCHED_VEL_SELECT_IN;
  logic                 SC_LANESCHED_PAUSE_IN;
  logic [NUM_LANES-1:0] SC_LANESCHED_LANE_EN_IN;
  logic [NUM_LANES-1:0] SC_LANESCHED_SHIFT_OUT;
  logic                 SC_LANESCHED_ROUND_DONE_OUT;
  logic [7:0]           SC_LANESCHED_ROUNDS_OUT;
  logic [1:0]           SC_LANESCHED_STATE_OUT;

  // Controller side (level state machine).
  modport master (
    output SC_LANESCHED_LOAD_SHIFT_IN,
    output SC_LANESCHED_VEL_SELECT_IN,
    output SC_LANESCHED_PAUSE_IN,
    output SC_LANESCHED_LANE_EN_IN,
    input  SC_LANESCHED_SHIFT_OUT,
    input  SC_LANESCHED_ROUND_DONE_OUT,
    input  SC_LANESCHED_ROUNDS_OUT,
    input  SC_LANESCHED_STATE_OUT
  );

  // Scheduler side.
  modport slave (
    input  SC_LANESCHED_LOAD_SHIFT_IN,
    input  SC_LANESCHED_VEL_SELECT_IN,
    input  SC_LANESCHED_PAUSE_IN,
    input  SC_LANESCHED_LANE_EN_IN,
    output SC_LANESCHED_SHIFT_OUT,
    output SC_LANESCHED_ROUND_DONE_OUT,
    output SC_LANESCHED_ROUNDS_OUT,
    output SC_LANESCHED_STATE_OUT
  );
endinterface

// File: rtl/sc_lane_shift_scheduler.sv
// sc_lane_shift_scheduler
// Divides the system clock by a speed-dependent period, then walks the lane
// slots in fixed order issuing one shift-enable pulse per enabled lane, and
// counts completed rounds.
//   SC_LANESCHED_CLOCK_50 : system clock, rising edge
//   SC_LANESCHED_RESET    : synchronous active-high reset
//   bus                   : scheduler side of sc_lane_shift_scheduler_if
module sc_lane_shift_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int DIV_WIDTH = 26,
  parameter int PERIOD_1  = 25000000,
  parameter int PERIOD_2  = 12500000,
  parameter int PERIOD_3  = 6250000
) (
  input  logic                      SC_LANESCHED_CLOCK_50,
  input  logic                      SC_LANESCHED_RESET,
  sc_lane_shift_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_COUNT = 2'b01;
  localparam logic [1:0] ST_ISSUE = 2'b10;

  // Counter reload is period-1 so that COUNT lasts exactly period cycles
  // (the cycle with counter=0 is the last COUNT cycle).
  function automatic logic [DIV_WIDTH-1:0] reload_value(input logic [1:0] vel);
    case (vel)
      2'b01:   reload_value = DIV_WIDTH'(PERIOD_1 - 1);
      2'b10:   reload_value = DIV_WIDTH'(PERIOD_2 - 1);
      2'b11:   reload_value = DIV_WIDTH'(PERIOD_3 - 1);
      default: reload_value = '0;
    endcase
  endfunction

  logic                 w_load;
  logic [1:0]           w_vel;
  logic                 w_pause;
  logic [NUM_LANES-1:0] w_lane_en;

  assign w_load    = bus.SC_LANESCHED_LOAD_SHIFT_IN;
  assign w_vel     = bus.SC_LANESCHED_VEL_SELECT_IN;
  assign w_pause   = bus.SC_LANESCHED_PAUSE_IN;
  assign w_lane_en = bus.SC_LANESCHED_LANE_EN_IN;

  logic [1:0]           r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_rounds;

  logic [1:0]           w_state_next;
  logic [DIV_WIDTH-1:0] w_cnt_next;
  logic [IDX_W-1:0]     w_idx_next;
  logic [7:0]           w_rounds_next;

  // State register.
  always_ff @(posedge SC_LANESCHED_CLOCK_50) begin
    if (SC_LANESCHED_RESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_rounds <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_rounds <= w_rounds_next;
    end
  end

  // Next-state logic. LOAD beats PAUSE beats normal transitions.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_idx_next    = r_idx;
    w_rounds_next = r_rounds;
    if (w_load) begin
      w_state_next  = ST_IDLE;
      w_idx_next    = '0;
      w_rounds_next = '0;
    end else if (r_state == 2'b11) begin
      // Illegal code recovers even while paused.
      w_state_next = ST_IDLE;
      w_idx_next   = '0;
    end else if (!w_pause) begin
      case (r_state)
        ST_IDLE: begin
          if (w_vel != 2'b00) begin
            w_state_next = ST_COUNT;
            w_cnt_next   = reload_value(w_vel);
          end
        end
        ST_COUNT: begin
          if (w_vel == 2'b00) begin
            w_state_next = ST_IDLE;
          end else if (r_cnt == '0) begin
            w_state_next = ST_ISSUE;
            w_idx_next   = '0;
          end else begin
            w_cnt_next = r_cnt - DIV_WIDTH'(1);
          end
        end
        ST_ISSUE: begin
          if (r_idx == LAST_IDX) begin
            // A stop request only takes effect once the round is complete.
            w_rounds_next = r_rounds + 8'd1;
            w_idx_next    = '0;
            if (w_vel != 2'b00) begin
              w_state_next = ST_COUNT;
              w_cnt_next   = reload_value(w_vel);
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode: slot select from the registered index.
  logic [NUM_LANES-1:0] w_slot;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_slot
      assign w_slot[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  logic                 w_issue_active;
  logic [NUM_LANES-1:0] w_shift;
  logic                 w_round_done;

  always_comb begin
    w_issue_active = (r_state == ST_ISSUE) && !w_load && !w_pause;
    w_shift        = '0;
    w_round_done   = 1'b0;
    if (w_issue_active) begin
      w_shift      = w_slot & w_lane_en;
      w_round_done = (r_idx == LAST_IDX);
    end
  end

  assign bus.SC_LANESCHED_SHIFT_OUT      = w_shift;
  assign bus.SC_LANESCHED_ROUND_DONE_OUT = w_round_done;
  assign bus.SC_LANESCHED_ROUNDS_OUT     = r_rounds;
  assign bus.SC_LANESCHED_STATE_OUT      = r_state;

endmodule
